uart_tx_frame: RTL and testbench

Parametrised UART transmitter: accepts one data word per valid/ready handshake and serialises it LSB-first on `tx` as start bit, data bits, optional parity bit, then one or two stop bits. Bit timing comes from a clock divider, so no separate baud clock domain is needed. The frame format is selectable per word. The block sits between the system bus logic and the serial pin, and replaces the fixed 8N1 transmitter in the UART datapath.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 24 ++
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states and parity-mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // 2'b11 is treated as "none", same as PAR_NONE
  function automatic logic par_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Frame-aligned bit timer: restart zeroes the count, bit_tick marks the last clock of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int              CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart)    r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + CW'(1);
  end

  assign bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, one or two stop bits.
// Every output is a register; the FSM computes next values and they land on the bit edge.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int            IW       = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [1:0]           r_mode;
  logic                 r_two_stop, r_stop, w_stop_nxt;
  logic                 r_par;
  logic                 r_tx, r_in_ready, r_busy, r_done;
  logic                 w_tx_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;
  logic                 w_accept, w_tick, w_emit;

  assign w_accept = in_valid && r_in_ready;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (w_accept),
    .bit_tick (w_tick)
  );

  // w_emit: the bit at r_shift[0] goes onto the line at this edge, so shift and fold it into parity
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_in_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_emit      = 1'b0;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        w_tx_nxt    = 1'b1;
        if (w_accept) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: if (w_tick) begin
        w_state_nxt = DATA;
        w_tx_nxt    = r_shift[0];
        w_emit      = 1'b1;
        w_idx_nxt   = '0;
      end
      DATA: if (w_tick) begin
        if (r_idx == LAST_IDX) begin
          w_stop_nxt = 1'b0;
          if (par_on(r_mode)) begin
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par ^ (r_mode == PAR_ODD);
          end else begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_tx_nxt  = r_shift[0];
          w_emit    = 1'b1;
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      PARITY: if (w_tick) begin
        w_state_nxt = STOP;
        w_tx_nxt    = 1'b1;
        w_stop_nxt  = 1'b0;
      end
      STOP: if (w_tick) begin
        if (r_two_stop && !r_stop) begin
          w_stop_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_stop     <= 1'b0;
      r_par      <= 1'b0;
      r_shift    <= '0;
      r_mode     <= PAR_NONE;
      r_two_stop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx       <= w_tx_nxt;
      r_in_ready <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_idx      <= w_idx_nxt;
      r_stop     <= w_stop_nxt;
      if (w_accept) begin
        r_shift    <= in_data;
        r_mode     <= parity_mode;
        r_two_stop <= two_stop;
        r_par      <= 1'b0;
      end else if (w_emit) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
        r_par   <= r_par ^ r_shift[0];
      end
    end
  end

  assign tx       = r_tx;
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit/4-clock instance and a 5-bit/2-clock instance,
// every line clock compared against a frame built from the data, parity and stop rules.
module tb_uart_tx_frame;

  localparam int CPB_A = 4;
  localparam int DB_A  = 8;
  localparam int CPB_B = 2;
  localparam int DB_B  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] pmode = 2'd0;
  logic       tstop = 1'b0;

  logic tx_a, rdy_a, busy_a, done_a;
  logic tx_b, rdy_b, busy_b, done_b;
  logic m_tx, m_rdy, m_busy, m_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A)) u_a (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(valid & ~sel), .in_ready(rdy_a),
    .parity_mode(pmode), .two_stop(tstop), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B)) u_b (
    .clk(clk), .rst(rst), .in_data(din[4:0]), .in_valid(valid & sel), .in_ready(rdy_b),
    .parity_mode(pmode), .two_stop(tstop), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  assign m_tx   = sel ? tx_b   : tx_a;
  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit time
  task automatic build(input logic [7:0] d, input logic [1:0] m, input logic ts,
                       output logic [15:0] bits, output int n);
    int db, ones;
    db   = sel ? DB_B : DB_A;
    bits = '0;
    ones = 0;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin
      bits[n] = d[i];
      ones    = ones + int'(d[i]);
      n       = n + 1;
    end
    if (m == 2'b01) begin bits[n] = ((ones % 2) == 1); n = n + 1; end
    if (m == 2'b10) begin bits[n] = ((ones % 2) == 0); n = n + 1; end
    bits[n] = 1'b1; n = n + 1;
    if (ts) begin bits[n] = 1'b1; n = n + 1; end
  endtask

  // Called at a negedge; returns just after the accepting posedge
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic ts, input bit hold);
    bit ok = 0;
    din = d; pmode = m; tstop = ts; valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (m_rdy) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", ok, 1'b1);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  // Checks every clock from the accept edge to the done edge; ends at the negedge after done
  task automatic frame(input logic [7:0] d, input logic [1:0] m, input logic ts, input bit poke);
    logic [15:0] bits;
    int n, c;
    build(d, m, ts, bits, n);
    c = sel ? CPB_B : CPB_A;
    for (int k = 0; k < n * c; k++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d]", k), m_tx, bits[k / c]);
      chk($sformatf("busy[%0d]", k), m_busy, 1'b1);
      chk($sformatf("done[%0d]", k), m_done, 1'b0);
      chk($sformatf("rdy[%0d]", k), m_rdy, 1'b0);
      if (poke && k == 3 * c) begin
        din = 8'($urandom); pmode = 2'($urandom_range(0, 3)); tstop = 1'($urandom_range(0, 1));
        valid = 1'b1;
      end
      if (poke && k == 3 * c + 1) valid = 1'b0;
    end
    @(negedge clk);
    chk("done_end", m_done, 1'b1);
    chk("rdy_end",  m_rdy,  1'b1);
    chk("busy_end", m_busy, 1'b0);
    chk("tx_end",   m_tx,   1'b1);
  endtask

  task automatic one(input logic [7:0] d, input logic [1:0] m, input logic ts, input bit poke);
    send(d, m, ts, 1'b0);
    frame(d, m, ts, poke);
    @(negedge clk);
    chk("done_pulse", m_done, 1'b0);
    chk("idle_tx",    m_tx,   1'b1);
    chk("idle_rdy",   m_rdy,  1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_tx_a",   tx_a,   1'b1);
    chk("rst_rdy_a",  rdy_a,  1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_tx_b",   tx_b,   1'b1);
    chk("rst_rdy_b",  rdy_b,  1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst_a", rdy_a, 1'b1);
    chk("rdy_after_rst_b", rdy_b, 1'b1);

    one(8'h55, 2'b00, 1'b0, 0);
    one(8'h07, 2'b01, 1'b0, 0);
    one(8'h00, 2'b10, 1'b1, 0);

    // back-to-back with in_valid held high through the first frame
    send(8'hA3, 2'b00, 1'b0, 1'b1);
    frame(8'hA3, 2'b00, 1'b0, 0);
    send(8'h3C, 2'b00, 1'b0, 1'b0);
    frame(8'h3C, 2'b00, 1'b0, 0);
    @(negedge clk);

    // new request mid-frame is ignored
    one(8'h5A, 2'b01, 1'b0, 1);

    // reset during data bit 3
    send(8'hC6, 2'b00, 1'b0, 1'b0);
    repeat (4 * CPB_A + 2) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx",   tx_a,   1'b1);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_rdy",  rdy_a,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a) saw = 1;
    end
    chk("no_done_after_rst", saw, 1'b0);
    chk("rdy_after_midrst", rdy_a, 1'b1);
    one(8'h96, 2'b11, 1'b1, 0);

    sel = 1'b1;
    @(negedge clk);
    one(8'h1F, 2'b00, 1'b0, 0);
    for (int i = 0; i < 10; i++)
      one(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);

    sel = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      one(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), i[0]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
